mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone-classic arbiter that shares the single CPU memory bus between the
//  mem stage (master 0, data/push/pop/exception frames) and instruction fetch (master 1). Fixed priority
//  to master 0 with a starvation guard for fetch, per-transaction grant locking, and an ack watchdog
//  that terminates hung cycles with an error so the pipeline stall cannot last forever.
// PARAMETERS
//  STARVE_LIMIT  4    consecutive m0 grants while m1 waits before m1 is forced to win (>=1)
//  TIMEOUT       255  cycles without s_ack_i before m*_err_o; 0 disables the watchdog
// PORTS
//  clk_i                  in   1   clock, rising edge
//  rst_i                  in   1   reset, asynchronous, active-high
//  m0_cyc_i / m1_cyc_i    in   1   master bus request / cycle in progress
//  m0_stb_i / m1_stb_i    in   1   master strobe
//  m0_we_i  / m1_we_i     in   1   master write enable
//  m0_adr_i / m1_adr_i    in   32  master byte address
//  m0_dat_i / m1_dat_i    in   32  master write data
//  m0_sel_i / m1_sel_i    in   4   master byte lane select
//  m0_ack_o / m1_ack_o    out  1   ack routed to granted master only
//  m0_err_o / m1_err_o    out  1   watchdog error, one-cycle pulse, granted master only
//  m0_dat_o / m1_dat_o    out  32  read data, both driven from s_dat_i
//  s_cyc_o, s_stb_o, s_we_o  out  1   slave cycle/strobe/write, from granted master
//  s_adr_o, s_dat_o       out  32  slave address / write data, from granted master
//  s_sel_o                out  4   slave byte select, from granted master
//  s_ack_i                in   1   slave ack
//  s_dat_i                in   32  slave read data
//  grant_o                out  2   one-hot {m1,m0} current grant; 2'b00 when idle
// BEHAVIOUR
//  - States IDLE, GNT0, GNT1 (registered). Slave-side mux is combinational from state.
//  - IDLE: all s_* outputs 0, ack/err 0. Decision on cycle with any m*_cyc_i: m0 wins unless
//    m1_cyc_i && (starve_cnt==STARVE_LIMIT || !m0_cyc_i). Grant visible next cycle (1-cycle latency).
//  - GNTx: s_* = mx_* ; s_cyc_o/s_stb_o = mx_cyc_i/mx_stb_i. Grant held while mx_cyc_i=1
//    (multi-beat/locked cycles never interrupted). mx_ack_o = s_ack_i; other master's ack/err = 0.
//  - Release: cycle where mx_cyc_i=0 in GNTx -> next state = GNT of other master if its cyc_i=1
//    (same priority rule as IDLE), else IDLE. Releasing master cannot re-grab without passing IDLE.
//  - starve_cnt: +1 on each transition into GNT0 while m1_cyc_i=1; saturates at STARVE_LIMIT;
//    cleared on entry to GNT1 and when m1_cyc_i=0 in IDLE. Width $clog2(STARVE_LIMIT+1).
//  - Watchdog: wd_cnt counts GNTx cycles with s_stb_o=1 && !s_ack_i; cleared on s_ack_i or state change.
//    When wd_cnt==TIMEOUT-1 and no ack: mx_err_o=1 that cycle, s_cyc_o/s_stb_o forced 0, next state IDLE;
//    arbiter ignores mx until it drops cyc for >=1 cycle (err_lock). s_ack_i same cycle as timeout wins.
//  - Reset (any time, incl. mid-transfer): state IDLE, grant_o=0, counters 0, err_lock 0; all
//    outputs driven from state so s_cyc_o/s_stb_o/ack/err go 0 immediately, asynchronously.
//  - No combinational path from m*_cyc_i to grant_o; m*_dat_o = s_dat_i unconditionally.
// TESTING
//  1 m0 read adr 0x100 alone -> grant_o=01 cycle after cyc, s_adr_o=0x100, m0_ack_o=s_ack_i, m1_ack_o=0.
//  2 m0,m1 raise cyc same cycle -> GNT0; m0 drops cyc -> GNT1 next cycle, no idle bubble.
//  3 m0 back-to-back requests, m1 held -> after 4 m0 grants m1 wins 5th decision; starve_cnt cleared.
//  4 m0 push held 3 beats (cyc high, stb pulsed) while m1 requests -> grant stays 01 all beats.
//  5 slave never acks, TIMEOUT=255 -> m0_err_o pulses at 255th stb cycle, s_cyc_o=0, state IDLE.
//  6 rst_i asserted mid GNT1 transfer -> s_cyc_o=0, grant_o=00 before next clock edge.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone-classic slave between the mem stage
// (master 0) and instruction fetch (master 1). Master 0 has fixed priority,
// fetch is protected from starvation, a granted cycle is never interrupted,
// and a watchdog ends cycles that the slave never acknowledges.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,   // m0 grants taken while m1 waits before m1 is forced in
    parameter int TIMEOUT      = 255  // unacked strobe cycles before error; 0 disables
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              WD_ON   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [SC_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic [1:0]      err_lock_reg, err_lock_next;

    // Master-side signals gathered into arrays so the per-master logic is shared.
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [1:0]  req;
    logic        granted, owner, cur_cyc, cur_stb, timeout;

    assign m_cyc    = {m1_cyc_i, m0_cyc_i};
    assign m_stb    = {m1_stb_i, m0_stb_i};
    assign m_we     = {m1_we_i,  m0_we_i};
    assign m_adr[0] = m0_adr_i;
    assign m_adr[1] = m1_adr_i;
    assign m_dat[0] = m0_dat_i;
    assign m_dat[1] = m1_dat_i;
    assign m_sel[0] = m0_sel_i;
    assign m_sel[1] = m1_sel_i;

    // A master that was cut off by the watchdog is invisible until it drops cyc.
    assign req     = m_cyc & ~err_lock_reg;
    assign granted = (state_reg != IDLE);
    assign owner   = (state_reg == GNT1);
    assign cur_cyc = granted & m_cyc[owner];
    assign cur_stb = cur_cyc & m_stb[owner];
    // An ack arriving in the same cycle as the limit rescues the transfer.
    assign timeout = WD_ON & cur_stb & ~s_ack_i & (wd_cnt_reg == WD_LAST);

    // Per-master ack/err routing and watchdog lockout.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign m_ack[gi]         = granted & (owner == 1'(gi)) & s_ack_i;
            assign m_err[gi]         = timeout & (owner == 1'(gi));
            assign err_lock_next[gi] = m_err[gi] ? 1'b1 :
                                       (!m_cyc[gi] ? 1'b0 : err_lock_reg[gi]);
        end
    endgenerate

    assign m0_ack_o = m_ack[0];
    assign m1_ack_o = m_ack[1];
    assign m0_err_o = m_err[0];
    assign m1_err_o = m_err[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {state_reg == GNT1, state_reg == GNT0};

    // Slave-side mux driven from the registered grant; a timeout kills cyc/stb at once.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        s_sel_o = 4'h0;
        if (granted) begin
            s_cyc_o = cur_cyc & ~timeout;
            s_stb_o = cur_stb & ~timeout;
            s_we_o  = m_we[owner];
            s_adr_o = m_adr[owner];
            s_dat_o = m_dat[owner];
            s_sel_o = m_sel[owner];
        end
    end

    // Next-state: fixed m0 priority with starvation override; grants held for the whole cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req[1] && (starve_cnt_reg == SC_MAX || !req[0]))
                    state_next = GNT1;
                else if (req[0])
                    state_next = GNT0;
            end
            GNT0: begin
                if (timeout)
                    state_next = IDLE;
                else if (!m_cyc[0])
                    state_next = req[1] ? GNT1 : IDLE;
            end
            GNT1: begin
                if (timeout)
                    state_next = IDLE;
                else if (!m_cyc[1])
                    state_next = req[0] ? GNT0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Starvation counter: counts m0 wins that happened while fetch was asking.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (state_next == GNT1 && state_reg != GNT1)
            starve_cnt_next = '0;
        else if (state_next == GNT0 && state_reg != GNT0 && m_cyc[1]) begin
            if (starve_cnt_reg != SC_MAX)
                starve_cnt_next = starve_cnt_reg + 1'b1;
        end else if (state_reg == IDLE && !m_cyc[1])
            starve_cnt_next = '0;
    end

    // Watchdog counter: unacked strobe cycles within one grant.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (state_next != state_reg || s_ack_i)
            wd_cnt_next = '0;
        else if (WD_ON && cur_stb)
            wd_cnt_next = wd_cnt_reg + 1'b1;
    end

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            wd_cnt_reg     <= '0;
            err_lock_reg   <= 2'b00;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            wd_cnt_reg     <= wd_cnt_next;
            err_lock_reg   <= err_lock_next;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for starvation, watchdog and asynchronous reset.
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        m0c, m0s, m0w;
        logic [31:0] m0a;
        logic        m1c, m1s;
        logic [31:0] m1a;
        logic        ack;
        logic [31:0] sdat;
        logic [1:0]  eg;
        logic        ecyc, estb, ewe;
        logic [31:0] eadr;
        logic        ea0, ea1;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic m0c, m0s, m0w, input logic [31:0] m0a,
                                input logic m1c, m1s, input logic [31:0] m1a,
                                input logic ack, input logic [31:0] sdat,
                                input logic [1:0] eg, input logic ecyc, estb, ewe,
                                input logic [31:0] eadr, input logic ea0, ea1);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m0w = m0w; v.m0a = m0a;
        v.m1c = m1c; v.m1s = m1s; v.m1a = m1a;
        v.ack = ack; v.sdat = sdat;
        v.eg = eg; v.ecyc = ecyc; v.estb = estb; v.ewe = ewe; v.eadr = eadr;
        v.ea0 = ea0; v.ea1 = ea1;
        return v;
    endfunction

    // Masters' write data and byte selects are fixed functions of their address.
    task automatic drive(input logic m0c, m0s, m0w, input logic [31:0] m0a,
                         input logic m1c, m1s, m1w, input logic [31:0] m1a,
                         input logic ack, input logic [31:0] sdat);
        m0_cyc_i = m0c; m0_stb_i = m0s; m0_we_i = m0w; m0_adr_i = m0a;
        m0_dat_i = ~m0a; m0_sel_i = 4'hF;
        m1_cyc_i = m1c; m1_stb_i = m1s; m1_we_i = m1w; m1_adr_i = m1a;
        m1_dat_i = m1a ^ 32'h5555_5555; m1_sel_i = 4'h6;
        s_ack_i = ack; s_dat_i = sdat;
    endtask

    function automatic logic [140:0] snap();
        return {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
    endfunction

    function automatic logic [140:0] expv(input logic [1:0] g, input logic cyc, stb, we,
                                          input logic [31:0] adr, input logic a0, a1, e0, e1,
                                          input logic [31:0] sdat, m0a, m1a);
        logic [31:0] d;
        logic [3:0]  sel;
        d   = (g == 2'b01) ? ~m0a : (g == 2'b10) ? (m1a ^ 32'h5555_5555) : 32'h0;
        sel = (g == 2'b01) ? 4'hF : (g == 2'b10) ? 4'h6 : 4'h0;
        return {g, cyc, stb, we, adr, d, sel, a0, a1, e0, e1, sdat, sdat};
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Key status bits for the multi-cycle sequences.
    function automatic logic [6:0] st();
        return {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_err_o};
    endfunction

    task automatic wd_run(input bit ack_last);
        logic [6:0] e;
        @(negedge clk_i);
        drive(1, 1, 0, 32'h600, 0, 0, 0, 0, 0, 0);
        #1 chk("wd_idle", grant_o, 2'b00);
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk_i);
            drive(1, 1, 0, 32'h600, 0, 0, 0, 0, (k == 255) && ack_last, 0);
            #1;
            if (k == 1 || k == 128 || k == 254 || k == 255) begin
                if (k < 255)       e = {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
                else if (ack_last) e = {2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
                else               e = {2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                chk($sformatf("wd%0d_k%0d", ack_last, k), st(), e);
            end
        end
        if (!ack_last) begin
            // Locked out while cyc stays high, even across several idle decisions.
            @(negedge clk_i); drive(1, 1, 0, 32'h600, 0, 0, 0, 0, 0, 0);
            #1 chk("wd_lock_a", st(), 7'b00_00000);
            @(negedge clk_i); drive(1, 1, 0, 32'h600, 0, 0, 0, 0, 0, 0);
            #1 chk("wd_lock_b", st(), 7'b00_00000);
            @(negedge clk_i); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1 chk("wd_drop", grant_o, 2'b00);
            @(negedge clk_i); drive(1, 1, 0, 32'h604, 0, 0, 0, 0, 0, 0);
            #1 chk("wd_rereq", grant_o, 2'b00);
            @(negedge clk_i); drive(1, 1, 0, 32'h604, 0, 0, 0, 0, 1, 0);
            #1 chk("wd_regrant", st(), {2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk_i); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk($sformatf("wd%0d_release", ack_last), grant_o, 2'b01);
        @(negedge clk_i);
        #1 chk($sformatf("wd%0d_idle_end", ack_last), grant_o, 2'b00);
    endtask

    initial begin
        // Single-cycle behaviour; state before each row is set by the rows above it.
        tbl[0]  = mk(0,0,0,32'h0,   0,0,32'h0,   0,32'h0,        2'b00,0,0,0,32'h0,  0,0);
        tbl[1]  = mk(1,1,0,32'h100, 0,0,32'h0,   1,32'hCAFE0001, 2'b00,0,0,0,32'h0,  0,0);
        tbl[2]  = mk(1,1,0,32'h100, 0,0,32'h0,   0,32'h0,        2'b01,1,1,0,32'h100,0,0);
        tbl[3]  = mk(1,1,0,32'h100, 0,0,32'h0,   1,32'h1234,     2'b01,1,1,0,32'h100,1,0);
        tbl[4]  = mk(0,0,0,32'h0,   0,0,32'h0,   0,32'h0,        2'b01,0,0,0,32'h0,  0,0);
        tbl[5]  = mk(1,1,1,32'h200, 1,1,32'h300, 0,32'h0,        2'b00,0,0,0,32'h0,  0,0);
        tbl[6]  = mk(1,1,1,32'h200, 1,1,32'h300, 1,32'h55,       2'b01,1,1,1,32'h200,1,0);
        tbl[7]  = mk(0,0,0,32'h0,   1,1,32'h300, 0,32'h0,        2'b01,0,0,0,32'h0,  0,0);
        tbl[8]  = mk(0,0,0,32'h0,   1,1,32'h300, 1,32'h77,       2'b10,1,1,0,32'h300,0,1);
        tbl[9]  = mk(1,1,1,32'h400, 0,0,32'h0,   0,32'h0,        2'b10,0,0,0,32'h0,  0,0);
        tbl[10] = mk(1,1,1,32'h400, 1,1,32'h500, 1,32'h88,       2'b01,1,1,1,32'h400,1,0);
        tbl[11] = mk(1,0,1,32'h404, 1,1,32'h500, 0,32'h0,        2'b01,1,0,1,32'h404,0,0);
        tbl[12] = mk(1,1,1,32'h404, 1,1,32'h500, 1,32'h99,       2'b01,1,1,1,32'h404,1,0);
        tbl[13] = mk(1,0,1,32'h408, 1,1,32'h500, 0,32'h0,        2'b01,1,0,1,32'h408,0,0);
        tbl[14] = mk(1,1,1,32'h408, 1,1,32'h500, 1,32'hAA,       2'b01,1,1,1,32'h408,1,0);
        tbl[15] = mk(0,0,0,32'h0,   1,1,32'h500, 0,32'h0,        2'b01,0,0,0,32'h0,  0,0);
        tbl[16] = mk(0,0,0,32'h0,   1,1,32'h500, 1,32'hBB,       2'b10,1,1,0,32'h500,0,1);
        tbl[17] = mk(0,0,0,32'h0,   0,0,32'h0,   0,32'h0,        2'b10,0,0,0,32'h0,  0,0);
        tbl[18] = mk(0,0,0,32'h0,   0,0,32'h0,   0,32'h0,        2'b00,0,0,0,32'h0,  0,0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        #2 chk("reset", snap(), expv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk_i);
            drive(tbl[i].m0c, tbl[i].m0s, tbl[i].m0w, tbl[i].m0a,
                  tbl[i].m1c, tbl[i].m1s, 1'b0, tbl[i].m1a, tbl[i].ack, tbl[i].sdat);
            #1 chk($sformatf("vec%0d", i), snap(),
                   expv(tbl[i].eg, tbl[i].ecyc, tbl[i].estb, tbl[i].ewe, tbl[i].eadr,
                        tbl[i].ea0, tbl[i].ea1, 1'b0, 1'b0, tbl[i].sdat,
                        tbl[i].m0a, tbl[i].m1a));
        end

        // Starvation: four m0 wins while fetch asks, then fetch takes the fifth decision.
        for (int r = 0; r < 6; r++) begin
            @(negedge clk_i);
            drive(1, 1, 0, 32'h800 + 32'(r), 1, 1, 0, 32'h900, 0, 0);
            #1 chk($sformatf("starve_r%0d_idle", r), grant_o, 2'b00);
            @(negedge clk_i);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1 chk($sformatf("starve_r%0d_gnt", r), grant_o, (r == 4) ? 2'b10 : 2'b01);
        end

        wd_run(1'b0);
        wd_run(1'b1);

        // Reset in the middle of a fetch transfer drops the bus before the next edge.
        @(negedge clk_i);
        drive(0, 0, 0, 0, 1, 1, 0, 32'h700, 0, 0);
        #1 chk("rst_idle", grant_o, 2'b00);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 1, 1, 0, 32'h700, 1, 0);
        #1 chk("rst_pre", {grant_o, s_cyc_o, s_stb_o, m1_ack_o}, 5'b10_111);
        #2 rst_i = 1'b1;
        #1 chk("rst_async", {grant_o, s_cyc_o, s_stb_o, m1_ack_o}, 5'b00_000);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("rst_after", snap(), expv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
